// File: rtl/color_swap_sequencer_if.sv
// Switch/sync inputs and committed swap outputs of the RGB channel-swap control block.
interface color_swap_sequencer_if;
    logic [9:0] iSW;
    logic       iVS_N;
    logic       oFILTER_EN;
    logic [2:0] oSWAP;
    logic       oPENDING;
    logic       oAPPLIED;

    modport master (output iSW, iVS_N, input oFILTER_EN, oSWAP, oPENDING, oAPPLIED);
    modport slave  (input iSW, iVS_N, output oFILTER_EN, oSWAP, oPENDING, oAPPLIED);
endinterface

// File: rtl/color_swap_sequencer.sv
// Debounces board switches and commits a new RGB swap config only at frame start.
// Define AUTO_CYCLE_EN to compile in auto-cycling through all eight swap combinations.
module color_swap_sequencer #(
    parameter int DEBOUNCE_CYCLES = 65536,
    parameter int FRAMES_PER_STEP = 60
) (
    input  logic iCLK,
    input  logic iRST,
    color_swap_sequencer_if.slave bus
);
`ifdef AUTO_CYCLE_EN
    localparam int SW_W = 5;
`else
    localparam int SW_W = 4;
`endif
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0] DB_PRE  = DB_W'(DEBOUNCE_CYCLES - 2);

    typedef enum logic [1:0] {S_IDLE, S_PEND, S_APPLY} state_t;

    logic [SW_W-1:0] sw_in, sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
    logic [SW_W-1:0] cand_q, cand_d, stable_q, stable_d;
    logic [DB_W-1:0] cnt_q, cnt_d;
    logic            vs_q, vs_d, fs, step, sw_unused;
    logic [3:0]      target, commit_q, commit_d;
    logic            pending_q, pending_d, applied_q, applied_d;
    state_t          state_q, state_d;

`ifdef AUTO_CYCLE_EN
    assign sw_in     = {bus.iSW[9], bus.iSW[8], bus.iSW[2:0]};
    assign sw_unused = ^bus.iSW[7:3];
`else
    assign sw_in     = {bus.iSW[9], bus.iSW[2:0]};
    assign sw_unused = ^bus.iSW[8:3];
`endif

    // Whole-vector debounce: stable copies the candidate as the counter lands on its last value.
    always_comb begin
        sw_s1_d  = sw_in;
        sw_s2_d  = sw_s1_q;
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (sw_s2_q != cand_q) begin
            cand_d = sw_s2_q;
            cnt_d  = '0;
        end else if (cnt_q != DB_LAST) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == DB_PRE) stable_d = cand_q;
        end
    end

    assign vs_d = bus.iVS_N;
    assign fs   = vs_q & ~bus.iVS_N;

`ifdef AUTO_CYCLE_EN
    localparam int FR_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam logic [FR_W-1:0] FR_LAST = FR_W'(FRAMES_PER_STEP - 1);

    logic [FR_W-1:0] fr_q, fr_d;
    logic [2:0]      asel_q, asel_d;
    logic            auto_act;

    always_comb begin
        auto_act = stable_q[4] & stable_q[3];
        step     = auto_act & fs & (fr_q == FR_LAST);
        fr_d     = fr_q;
        asel_d   = asel_q;
        if (!auto_act)  fr_d = '0;
        else if (fs)    fr_d = (fr_q == FR_LAST) ? '0 : fr_q + 1'b1;
        if (step)       asel_d = asel_q + 3'd1;
        target = auto_act ? {1'b1, asel_q} : {stable_q[4], stable_q[2:0]};
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            fr_q   <= '0;
            asel_q <= '0;
        end else begin
            fr_q   <= fr_d;
            asel_q <= asel_d;
        end
    end
`else
    assign step   = 1'b0;
    assign target = stable_q;
`endif

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // An auto step forces an apply on its own frame start; manual changes wait in PEND.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (step)                    state_d = S_APPLY;
                     else if (target != commit_q) state_d = S_PEND;
            S_PEND:  if (step)                    state_d = S_APPLY;
                     else if (target == commit_q) state_d = S_IDLE;
                     else if (fs)                 state_d = S_APPLY;
            default:                              state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pending_d = (state_d == S_PEND);
        applied_d = (state_q == S_APPLY);
        commit_d  = (state_q == S_APPLY) ? target : commit_q;
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            sw_s1_q   <= '0;
            sw_s2_q   <= '0;
            cand_q    <= '0;
            cnt_q     <= '0;
            stable_q  <= '0;
            vs_q      <= 1'b1;
            commit_q  <= '0;
            pending_q <= 1'b0;
            applied_q <= 1'b0;
        end else begin
            sw_s1_q   <= sw_s1_d;
            sw_s2_q   <= sw_s2_d;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            stable_q  <= stable_d;
            vs_q      <= vs_d;
            commit_q  <= commit_d;
            pending_q <= pending_d;
            applied_q <= applied_d;
        end
    end

    assign bus.oFILTER_EN = commit_q[3];
    assign bus.oSWAP      = commit_q[2:0];
    assign bus.oPENDING   = pending_q;
    assign bus.oAPPLIED   = applied_q;
endmodule

// File: tb/tb_color_swap_sequencer.sv
// Bench for color_swap_sequencer: directed steps plus random switch traffic, every cycle
// compared against a window-based reference model of debounce, frame-start commit and auto-cycle.
module tb_color_swap_sequencer;
    localparam int DEB = 4;
    localparam int FPS = 2;
`ifdef AUTO_CYCLE_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic iCLK = 1'b0;
    logic iRST;
    color_swap_sequencer_if bus();

    color_swap_sequencer #(.DEBOUNCE_CYCLES(DEB), .FRAMES_PER_STEP(FPS)) dut (
        .iCLK(iCLK), .iRST(iRST), .bus(bus));

    always #5 iCLK = ~iCLK;

    int total = 0, bad = 0;
    int fcyc;
    bit seen_pend, seen_app;

    // reference model
    logic [4:0] h [0:DEB+1];
    logic [4:0] st;
    logic [3:0] com;
    logic [2:0] asel;
    int         fr;
    bit         pd, ap, app_m, vsp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i <= DEB + 1; i++) h[i] = '0;
        st = '0; com = '0; asel = '0; fr = 0;
        pd = 0; ap = 0; app_m = 0; vsp = 1;
    endtask

    task automatic model_step();
        logic [3:0] tgt;
        bit fs, step, aon, same;
        if (iRST) begin model_reset(); return; end
        aon  = AUTO && st[4] && st[3];
        tgt  = aon ? {1'b1, asel} : {st[4], st[2:0]};
        fs   = vsp && !bus.iVS_N;
        step = aon && fs && (fr == FPS - 1);
        app_m = 0;
        if (ap) begin
            com = tgt; app_m = 1; ap = 0; pd = 0;
        end else if (step) begin
            ap = 1; pd = 0;
        end else if (pd) begin
            if (tgt == com) pd = 0;
            else if (fs) begin ap = 1; pd = 0; end
        end else if (tgt != com) pd = 1;
        if (!aon) fr = 0;
        else if (fs) begin
            if (fr == FPS - 1) begin fr = 0; asel = asel + 3'd1; end
            else fr++;
        end
        vsp = bus.iVS_N;
        // stable takes a value once the synchronised input has held it DEB consecutive samples
        for (int i = DEB + 1; i > 0; i--) h[i] = h[i-1];
        h[0] = {bus.iSW[9], bus.iSW[8], bus.iSW[2:0]};
        same = 1;
        for (int i = 3; i <= DEB + 1; i++) if (h[i] != h[2]) same = 0;
        if (same) st = h[2];
    endtask

    task automatic tick();
        @(posedge iCLK);
        model_step();
        #1;
        chk("m_fe", bus.oFILTER_EN, com[3]);
        chk("m_swap", bus.oSWAP, com[2:0]);
        chk("m_pend", bus.oPENDING, pd);
        chk("m_app", bus.oAPPLIED, app_m);
        seen_pend |= bus.oPENDING;
        seen_app  |= bus.oAPPLIED;
        fcyc = (fcyc + 1) % 100;
        bus.iVS_N = (fcyc < 10) ? 1'b0 : 1'b1;
    endtask

    task automatic wait_pos(input int p);
        while (fcyc != p) tick();
    endtask

    task automatic wait_applied(input string tag, input int lim, output int n);
        bit got = 0;
        n = 0;
        while (!got && n < lim) begin
            tick(); n++;
            got = bus.oAPPLIED;
        end
        chk(tag, got, 1);
    endtask

    initial begin
        int n;
        logic [2:0] q [$];
        iRST = 1; bus.iSW = '0; fcyc = 50; bus.iVS_N = 1'b1;
        model_reset();
        repeat (3) tick();
        chk("rst_fe", bus.oFILTER_EN, 0);
        chk("rst_swap", bus.oSWAP, 0);
        chk("rst_pend", bus.oPENDING, 0);
        chk("rst_app", bus.oAPPLIED, 0);
        iRST = 0;

        // first commit: pending after 7 cycles, applied at next frame start
        bus.iSW = 10'h201;
        repeat (6) tick();
        chk("pend_lat_early", bus.oPENDING, 0);
        tick();
        chk("pend_lat", bus.oPENDING, 1);
        wait_applied("apply1_seen", 200, n);
        chk("apply1_fe", bus.oFILTER_EN, 1);
        chk("apply1_swap", bus.oSWAP, 3'b001);
        chk("apply1_pend", bus.oPENDING, 0);
        tick();
        chk("apply1_pulse", bus.oAPPLIED, 0);

        // bounce shorter than the debounce window
        wait_pos(40);
        seen_pend = 0; seen_app = 0;
        for (int i = 0; i < 10; i++) begin
            bus.iSW[0] = ~bus.iSW[0];
            repeat (2) tick();
        end
        bus.iSW = 10'h201;
        repeat (10) tick();
        chk("bounce_pend", seen_pend, 0);
        chk("bounce_app", seen_app, 0);
        chk("bounce_swap", bus.oSWAP, 3'b001);

        // change then revert before frame start
        wait_pos(15);
        seen_app = 0;
        bus.iSW = 10'h204;
        repeat (7) tick();
        chk("revert_pend_up", bus.oPENDING, 1);
        bus.iSW = 10'h201;
        repeat (7) tick();
        chk("revert_pend_down", bus.oPENDING, 0);
        chk("revert_app", seen_app, 0);
        chk("revert_swap", bus.oSWAP, 3'b001);

        // target changes in the same cycle as frame start: applied one frame later
        wait_pos(94);
        bus.iSW = 10'h205;
        repeat (7) tick();
        chk("samefs_pend", bus.oPENDING, 1);
        repeat (2) tick();
        chk("samefs_noapp", bus.oAPPLIED, 0);
        wait_applied("samefs_seen", 200, n);
        chk("samefs_delay", n, 99);
        chk("samefs_swap", bus.oSWAP, 3'b101);

`ifdef AUTO_CYCLE_EN
        bus.iSW = 10'h300;
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (bus.oAPPLIED) q.push_back(bus.oSWAP);
        end
        chk("auto_fe", bus.oFILTER_EN, 1);
        chk("auto_count", (q.size() >= 9), 1);
        for (int i = 2; i < q.size(); i++) chk("auto_step", q[i], q[i-1] + 3'd1);
        bus.iSW = 10'h200;
        repeat (300) tick();
        chk("auto_exit_swap", bus.oSWAP, 3'b000);
`endif

        // random switch traffic
        for (int s = 0; s < 300; s++) begin
            bus.iSW = 10'($urandom);
            if ($urandom_range(0, 3) != 0) bus.iSW[9] = 1'b1;
            repeat ($urandom_range(1, 30)) tick();
        end

        // async reset while pending
        wait_pos(30);
        bus.iSW = {1'b1, 1'b0, 5'b0, ~com[2:0]};
        repeat (7) tick();
        chk("rstp_pend", bus.oPENDING, 1);
        #2 iRST = 1; model_reset();
        #1;
        chk("rstp_fe", bus.oFILTER_EN, 0);
        chk("rstp_swap", bus.oSWAP, 0);
        chk("rstp_pend0", bus.oPENDING, 0);
        chk("rstp_app", bus.oAPPLIED, 0);
        repeat (2) tick();
        iRST = 0;
        seen_app = 0;
        repeat (6) tick();
        chk("rstp_noapp", seen_app, 0);
        repeat (250) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
